svc_soc_uart_rx_reg: RTL

- Memory-mapped UART receiver peripheral for the RISC-V SoC; the receive counterpart of the existing UART transmit path in the I/O register bank.
- Deserializes 8N1 frames from `urx_pin` into a small FIFO.
- Exposes data and status registers on the SoC `io_*` read/write bus.
- In simulation, the sim UART terminal drives `urx_pin`, so software can read console input.

---
 rtl/svc_soc_uart_rx_pkg.sv | 29 ++
 rtl/svc_soc_uart_rx_reg_if.sv | 13 +
 rtl/svc_soc_uart_rx_fifo.sv | 56 +++++
 rtl/svc_soc_uart_rx_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/svc_soc_uart_rx_pkg.sv
// Shared types and constants for the SoC UART receive peripheral.
// Optional 8E1 framing is enabled by defining SVC_SOC_UART_RX_PARITY_EN.
package svc_soc_uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SVC_SOC_UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

    localparam logic [31:0] UART_RX_DATA_OFF   = 32'd0;
    localparam logic [31:0] UART_RX_STATUS_OFF = 32'd4;

    localparam int STAT_AVAIL_BIT = 0;
    localparam int STAT_OVR_BIT   = 1;
    localparam int STAT_FERR_BIT  = 2;
    localparam int STAT_PERR_BIT  = 3;
    localparam int STAT_CNT_LSB   = 4;

    // The STATUS count field is only 4 bits, so deeper FIFOs saturate at 15.
    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/svc_soc_uart_rx_reg_if.sv
// SoC io_* read/write bus as seen by the UART receive peripheral.
interface svc_soc_uart_rx_reg_if;
    logic        ren;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    modport master (output ren, raddr, wen, waddr, wdata, wstrb, input rdata);
    modport slave  (input ren, raddr, wen, waddr, wdata, wstrb, output rdata);
endinterface

// File: rtl/svc_soc_uart_rx_fifo.sv
// Synchronous FIFO for received bytes; a same-cycle pop frees room for a push.
module svc_soc_uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PW + 1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/svc_soc_uart_rx_reg.sv
// Memory-mapped UART receiver: synchronizer, receive FSM, FIFO and DATA/STATUS registers.
// Define SVC_SOC_UART_RX_PARITY_EN for 8E1 framing with a sticky PERR flag.
module svc_soc_uart_rx_reg
    import svc_soc_uart_rx_pkg::*;
#(
    parameter int          CLOCK_FREQ = 100_000_000,
    parameter int          BAUD_RATE  = 115_200,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0010
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  urx_pin,
    svc_soc_uart_rx_reg_if.slave  io,
    output logic                  rx_avail
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          sync1, rx_s, rx_prev;
    rx_state_t     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift, shift_next;

    logic          fifo_full, fifo_empty, fifo_pop, frame_push;
    logic [7:0]    fifo_head;
    logic [PW:0]   fifo_count;

    logic          set_ovr, set_ferr, ovr, ferr, perr;
    logic          rd_data_hit, rd_stat_hit, wr_clr;
    logic [31:0]   status_word;

`ifdef SVC_SOC_UART_RX_PARITY_EN
    logic          set_perr, parity_bad, parity_bad_next;
`else
    logic          unused_wdata;
    assign unused_wdata = ^{io.wdata[31:4], io.wdata[3], io.wdata[0], io.wstrb[3:1]};
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detection; idle-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= urx_pin;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef SVC_SOC_UART_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
`ifdef SVC_SOC_UART_RX_PARITY_EN
            parity_bad <= parity_bad_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        frame_push = 1'b0;
        set_ovr    = 1'b0;
        set_ferr   = 1'b0;
`ifdef SVC_SOC_UART_RX_PARITY_EN
        set_perr        = 1'b0;
        parity_bad_next = parity_bad;
`endif
        case (state)
            ST_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_next = ST_START;
                    cnt_next   = '0;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? ST_IDLE : ST_DATA;
`ifdef SVC_SOC_UART_RX_PARITY_EN
                    parity_bad_next = 1'b0;
`endif
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
`ifdef SVC_SOC_UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
`ifdef SVC_SOC_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_STOP;
                    if (rx_s != ^shift) begin
                        set_perr        = 1'b1;
                        parity_bad_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                    if (!rx_s) begin
                        set_ferr = 1'b1;
`ifdef SVC_SOC_UART_RX_PARITY_EN
                    end else if (parity_bad) begin
                        frame_push = 1'b0;
`endif
                    end else if (!fifo_full || fifo_pop) begin
                        frame_push = 1'b1;
                    end else begin
                        set_ovr = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    svc_soc_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (frame_push),
        .push_data (shift),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rx_avail    = (fifo_count != '0);
    assign rd_data_hit = (io.raddr == BASE_ADDR + UART_RX_DATA_OFF);
    assign rd_stat_hit = (io.raddr == BASE_ADDR + UART_RX_STATUS_OFF);
    assign fifo_pop    = io.ren && rd_data_hit && !fifo_empty;
    assign wr_clr      = io.wen && (io.waddr == BASE_ADDR + UART_RX_STATUS_OFF) && io.wstrb[0];

    always_comb begin
        status_word                           = '0;
        status_word[STAT_AVAIL_BIT]           = rx_avail;
        status_word[STAT_OVR_BIT]             = ovr;
        status_word[STAT_FERR_BIT]            = ferr;
        status_word[STAT_PERR_BIT]            = perr;
        status_word[STAT_CNT_LSB +: 4]        = sat_count(32'(fifo_count));
    end

    // Sticky flags: a same-cycle set beats a write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= set_ovr  | (ovr  & ~(wr_clr & io.wdata[STAT_OVR_BIT]));
            ferr <= set_ferr | (ferr & ~(wr_clr & io.wdata[STAT_FERR_BIT]));
        end
    end

`ifdef SVC_SOC_UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr <= 1'b0;
        end else begin
            perr <= set_perr | (perr & ~(wr_clr & io.wdata[STAT_PERR_BIT]));
        end
    end
`else
    assign perr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io.rdata <= '0;
        end else if (io.ren && rd_data_hit) begin
            io.rdata <= fifo_empty ? 32'd0 : {24'd0, fifo_head};
        end else if (io.ren && rd_stat_hit) begin
            io.rdata <= status_word;
        end else begin
            io.rdata <= '0;
        end
    end

endmodule
